// File: rtl/ssriscv_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ssriscv_ifu_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } iq_entry_t;

endpackage

// File: rtl/ssriscv_ifu_fetch_if.sv
// Fetch-stage bundle: PC loop, imem request/response, redirect, decode side.
interface ssriscv_ifu_fetch_if;
    import ssriscv_ifu_pkg::*;

    logic [31:0] pc_now;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_fault;

    modport master (
        input  pc_now,
        output pc_next,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_pc,
        output id_fault
    );

    modport slave (
        output pc_now,
        input  pc_next,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_pc,
        input  id_fault
    );

endinterface

// File: rtl/ssriscv_ifu_tagfifo.sv
// Small synchronous FIFO with occupancy output, used for PC tags and the
// instruction queue.
module ssriscv_ifu_tagfifo
    import ssriscv_ifu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= f_inc(r_wptr);
            end
            if (w_pop) r_rptr <= f_inc(r_rptr);
            if (i_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!i_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && r_count == CW'(DEPTH)));

endmodule

// File: rtl/ssriscv_ifu_fetch.sv
// Fetch stage: credit-limited in-order imem requests, PC tagging,
// redirect discard and the decode-facing instruction queue.
module ssriscv_ifu_fetch
    import ssriscv_ifu_pkg::*;
#(
    parameter int IQ_DEPTH      = 2,
    parameter int PC_FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    ssriscv_ifu_fetch_if.master bus
);

    localparam int            CW     = $clog2(IQ_DEPTH + 1);
    localparam int            TW     = $clog2(PC_FIFO_DEPTH + 1);
    localparam logic [CW:0]   IQ_MAX = (CW + 1)'(IQ_DEPTH);

    logic          r_started;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_q_cnt;
    logic          w_q_empty;
    iq_entry_t     w_q_head;
    iq_entry_t     w_q_wdata;
    logic [31:0]   w_tag;
    logic [TW-1:0] w_tag_cnt;
    logic          w_tag_empty;
    logic [CW:0]   w_used;
    logic          w_req_valid;
    logic          w_fire;
    logic          w_rsp;
    logic          w_drop;
    logic          w_q_push;
    logic          w_q_pop;

    assign w_used      = {1'b0, w_q_cnt} + {1'b0, r_out};
    assign w_req_valid = r_started && !bus.redirect_valid && (w_used < IQ_MAX);
    assign w_fire      = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    // Responses in the redirect cycle belong to the old stream as well.
    assign w_drop      = bus.redirect_valid || (r_discard != '0);
    assign w_q_push    = w_rsp && !w_drop;
    assign w_q_pop     = !w_q_empty && bus.id_ready && !bus.redirect_valid;
    assign w_q_wdata   = '{inst: bus.imem_rsp_data, pc: w_tag,
                           fault: bus.imem_rsp_err};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = bus.pc_now;
    assign bus.id_valid       = !w_q_empty;
    assign bus.id_inst        = w_q_head.inst;
    assign bus.id_pc          = w_q_head.pc;
    assign bus.id_fault       = w_q_head.fault;

    always_comb begin
        bus.pc_next = bus.pc_now;
        unique case (1'b1)
            bus.redirect_valid: bus.pc_next = bus.redirect_pc;
            w_fire:             bus.pc_next = bus.pc_now + PC_INC;
            default:            bus.pc_next = bus.pc_now;
        endcase
    end

    always_comb begin
        w_out_nxt = r_out;
        if (w_fire && !w_rsp) w_out_nxt = r_out + 1'b1;
        else if (!w_fire && w_rsp) w_out_nxt = r_out - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_out     <= '0;
            r_discard <= '0;
        end else begin
            r_started <= 1'b1;
            r_out     <= w_out_nxt;
            if (bus.redirect_valid) r_discard <= w_out_nxt;
            else if (w_rsp && r_discard != '0) r_discard <= r_discard - 1'b1;
        end
    end

    ssriscv_ifu_tagfifo #(
        .WIDTH (32),
        .DEPTH (PC_FIFO_DEPTH)
    ) u_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (1'b0),
        .i_push  (w_fire),
        .i_wdata (bus.pc_now),
        .i_pop   (w_rsp),
        .o_rdata (w_tag),
        .o_count (w_tag_cnt),
        .o_empty (w_tag_empty)
    );

    ssriscv_ifu_tagfifo #(
        .WIDTH ($bits(iq_entry_t)),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.redirect_valid),
        .i_push  (w_q_push),
        .i_wdata (w_q_wdata),
        .i_pop   (w_q_pop),
        .o_rdata (w_q_head),
        .o_count (w_q_cnt),
        .o_empty (w_q_empty)
    );

    a_tag_tracks_out: assert property (@(posedge clk) disable iff (!rst_n)
        w_tag_cnt == TW'(r_out));
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp && w_tag_empty));

endmodule

// File: tb/tb_ssriscv_ifu_fetch.sv
// Scoreboard bench: directed fetch scenarios plus randomized traffic.
module tb_ssriscv_ifu_fetch;
    import ssriscv_ifu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ssriscv_ifu_fetch_if bus();

    ssriscv_ifu_fetch #(
        .IQ_DEPTH      (2),
        .PC_FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // PC register: reset vector 0, loads pc_next every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.pc_now <= '0;
        else bus.pc_now <= bus.pc_next;
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          n_fire, n_deliv, n_fault;
    int          rr_pct, idr_pct, rsp_pct;
    int          d0, base;
    iq_entry_t   sb[$];
    logic [31:0] memq[$];
    logic [31:0] exp_pc;
    logic [31:0] last_fire;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          err_any = 1'b0;
    logic        m_fire;
    logic [31:0] m_pn;
    logic [31:0] m_a;
    iq_entry_t   m_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        return (a == err_addr) || (err_any && a[4:2] == 3'd5);
    endfunction

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: request stream, PC loop and decode deliveries.
    always @(negedge clk) begin
        if (rst_n) begin
            m_fire = bus.imem_req_valid && bus.imem_req_ready;
            m_pn = bus.redirect_valid ? bus.redirect_pc :
                   m_fire ? bus.pc_now + 32'd4 : bus.pc_now;
            chk("pc_next", bus.pc_next, m_pn);
            if (bus.redirect_valid) begin
                chk("req_in_redirect", bus.imem_req_valid, 0);
                sb.delete();
                exp_pc = bus.redirect_pc;
            end else if (bus.id_valid && bus.id_ready) begin
                n_deliv++;
                if (bus.id_fault) n_fault++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_id: id_pc=%h nothing expected",
                             bus.id_pc);
                end else begin
                    m_e = sb.pop_front();
                    chk("id_entry", {bus.id_inst, bus.id_pc, bus.id_fault}, m_e);
                end
            end
            if (m_fire) begin
                m_a = bus.imem_req_addr;
                chk("req_addr", m_a, exp_pc);
                last_fire = m_a;
                memq.push_back(m_a);
                sb.push_back('{inst: mem_word(m_a), pc: m_a, fault: err_of(m_a)});
                exp_pc = exp_pc + 32'd4;
                n_fire++;
            end
        end
    end

    task automatic step(input bit rv = 1'b0, input logic [31:0] rpc = 32'h0);
        logic [31:0] a;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rv ? rpc : 32'h0;
        bus.imem_req_ready = (int'($urandom_range(99)) < rr_pct);
        bus.id_ready       = (int'($urandom_range(99)) < idr_pct);
        if (memq.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
            a = memq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(a);
            bus.imem_rsp_err   = err_of(a);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
            bus.imem_rsp_err   = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.id_ready       = 1'b0;
        memq.delete();
        sb.delete();
        exp_pc  = 32'h0;
        n_fire  = 0;
        n_deliv = 0;
        n_fault = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.id_valid, bus.imem_req_valid, bus.id_inst,
                              bus.id_pc, bus.id_fault}, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_id();
        for (int k = 0; k < 30 && !bus.id_valid; k++) step();
    endtask

    initial begin
        logic [31:0] tgt;
        int r;
        rr_pct = 100; idr_pct = 100; rsp_pct = 100;

        do_reset();
        #1;
        chk("no_req_before_start", bus.imem_req_valid, 0);
        step();
        chk("first_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});
        step();
        chk("no_id_before_rsp", bus.id_valid, 0);
        step();
        chk("id_after_rsp", {bus.id_valid, bus.id_pc}, {1'b1, 32'h0});
        repeat (20) step();
        chk("stream_progress", (n_deliv >= 8), 1);

        idr_pct = 0;
        do_reset();
        repeat (10) step();
        chk("bp_fires", n_fire, 2);
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_pc_now", bus.pc_now, 32'h8);
        chk("bp_pc_next", bus.pc_next, 32'h8);
        idr_pct = 100;
        base = n_fire;
        for (int k = 0; k < 10 && n_fire == base; k++) step();
        chk("bp_resume_addr", last_fire, 32'h8);

        rsp_pct = 0;
        do_reset();
        repeat (5) step();
        chk("rd_outstanding", n_fire, 2);
        step(1'b1, 32'h100);
        rsp_pct = 100;
        d0 = n_deliv;
        wait_id();
        chk("rd_first_pc", {bus.id_valid, bus.id_pc}, {1'b1, 32'h100});
        chk("rd_dropped", n_deliv, d0);

        do_reset();
        for (int k = 0; k < 10 && memq.size() == 0; k++) step();
        chk("dr_rsp_pending", (memq.size() > 0), 1);
        step(1'b1, 32'h180);
        step(1'b1, 32'h200);
        d0 = n_deliv;
        wait_id();
        chk("dr_first_pc", {bus.id_valid, bus.id_pc}, {1'b1, 32'h200});
        chk("dr_no_stale", n_deliv, d0);

        err_addr = 32'h4;
        do_reset();
        repeat (20) step();
        chk("err_faults", n_fault, 1);
        err_addr = 32'hFFFF_FFFF;

        idr_pct = 0;
        do_reset();
        repeat (10) step();
        chk("mr_full", {bus.id_valid, bus.imem_req_valid}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_clear", {bus.id_valid, bus.imem_req_valid, bus.id_inst,
                               bus.id_pc, bus.id_fault}, 0);
        idr_pct = 100;
        do_reset();
        step();
        chk("mr_restart", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});

        rr_pct = 70; idr_pct = 60; rsp_pct = 60; err_any = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(99));
            if (r < 3) begin
                tgt = $urandom();
                tgt[1:0] = 2'b00;
                if (r == 0) tgt = 32'hFFFF_FFF8;
                step(1'b1, tgt);
            end else begin
                step();
            end
        end

        rr_pct = 0; rsp_pct = 100; idr_pct = 100;
        for (int k = 0; k < 50 && (memq.size() > 0 || bus.id_valid); k++) step();
        chk("drain_done", {(memq.size() == 0), bus.id_valid}, 2'b10);
        chk("drain_sb", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d checks %0d errors",
                 n_chk, n_err);
        $fatal(1);
    end

endmodule
